// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Raster timing generator. Free-running pixel/line counters,
//               registered sync / blanking / strobe decodes that are coherent
//               with the counters, a delay line that aligns the syncs and the
//               blanking gate with the pipelined colour from the frame buffer,
//               and the final colour blanking gate.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DELAY = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       colour_in,
  output logic [9:0] counter_H,
  output logic [9:0] counter_V,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       display_on_d,
  output logic       pixel_out
);

  // Raster geometry, all reduced to the 10-bit counter width.
  localparam int         H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int         V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic       SYNC_IDLE  = ~SYNC_POL;

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_in_sync;
  logic       v_in_sync;
  logic       active_next;

  // Next raster position: horizontal wrap carries into the line counter.
  always_comb begin
    h_next = counter_H + 10'd1;
    v_next = counter_V;
    if (counter_H == H_LAST) begin
      h_next = '0;
      if (counter_V == V_LAST) begin
        v_next = '0;
      end else begin
        v_next = counter_V + 10'd1;
      end
    end
  end

  // Decode windows from the next position so registered outputs line up
  // with the counters they describe.
  always_comb begin
    h_in_sync   = (h_next >= HS_START) && (h_next < HS_END);
    v_in_sync   = (v_next >= VS_START) && (v_next < VS_END);
    active_next = (h_next < H_ACT) && (v_next < V_ACT);
  end

  // Counters and undelayed decodes.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      counter_H   <= '0;
      counter_V   <= '0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      counter_H   <= h_next;
      counter_V   <= v_next;
      hsync       <= h_in_sync ? SYNC_POL : SYNC_IDLE;
      vsync       <= v_in_sync ? SYNC_POL : SYNC_IDLE;
      display_on  <= active_next;
      line_start  <= (h_next == 10'd0);
      frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
    end
  end

  // Delay line matching the frame buffer read latency.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hsync_d      = hsync;
    assign vsync_d      = vsync;
    assign display_on_d = display_on;
  end else begin : g_delay
    logic hs_pipe [PIPE_DELAY];
    logic vs_pipe [PIPE_DELAY];
    logic de_pipe [PIPE_DELAY];

    // Shift every cycle; reset flushes every stage to the idle levels so no
    // partial sync pulse leaks out after a reset.
    always_ff @(posedge clk_in) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          hs_pipe[i] <= SYNC_IDLE;
          vs_pipe[i] <= SYNC_IDLE;
          de_pipe[i] <= 1'b0;
        end
      end else begin
        hs_pipe[0] <= hsync;
        vs_pipe[0] <= vsync;
        de_pipe[0] <= display_on;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_pipe[i] <= hs_pipe[i-1];
          vs_pipe[i] <= vs_pipe[i-1];
          de_pipe[i] <= de_pipe[i-1];
        end
      end
    end

    assign hsync_d      = hs_pipe[PIPE_DELAY-1];
    assign vsync_d      = vs_pipe[PIPE_DELAY-1];
    assign display_on_d = de_pipe[PIPE_DELAY-1];
  end

  // Blank the returning colour outside the visible area.
  assign pixel_out = colour_in & display_on_d;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster timing that drives the frame buffer controller: free-running horizontal/vertical pixel counters (counter_H, counter_V), plus hsync, vsync, display_on and line/frame strobes.
- Also carries a delay line, so the syncs and the blanking gate line up with the pipelined colour that comes back from the frame buffer controller.
- Blanks that colour into pixel_out.
- Sits at the top of the video path, feeding counter_H/counter_V downstream and gating colour on the way out.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
PIPE_DELAY, 3, cycles from counter change to valid colour_in (0..15)

Ports:
clk_in  input  1  pixel clock; sole clock
reset  input  1  synchronous, active-high reset
colour_in  input  1  pixel colour from frame buffer controller (0 black, 1 white)
counter_H  output  10  horizontal pixel count, 0..H_TOTAL-1
counter_V  output  10  vertical line count, 0..V_TOTAL-1
hsync  output  1  undelayed hsync, aligned with counters
vsync  output  1  undelayed vsync, aligned with counters
display_on  output  1  1 when counter_H<H_ACTIVE and counter_V<V_ACTIVE
line_start  output  1  1-cycle strobe when counter_H==0
frame_start  output  1  1-cycle strobe when counter_H==0 and counter_V==0
hsync_d  output  1  hsync delayed PIPE_DELAY cycles
vsync_d  output  1  vsync delayed PIPE_DELAY cycles
display_on_d  output  1  display_on delayed PIPE_DELAY cycles
pixel_out  output  1  colour_in & display_on_d (combinational gate)

Behaviour:
- Totals:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
  - All counter arithmetic is 10-bit unsigned.
- Reset (sampled on clk_in while reset=1):
  - counter_H=0, counter_V=0.
  - hsync, vsync, hsync_d, vsync_d = ~SYNC_POL.
  - display_on, display_on_d, line_start, frame_start = 0.
  - All delay-line stages are loaded with these inactive values; pixel_out therefore = 0.
- Counting:
  - Every cycle out of reset, counter_H increments.
  - At counter_H==H_TOTAL-1 it wraps to 0 and counter_V increments on the same edge.
  - At counter_V==V_TOTAL-1 with counter_H==H_TOTAL-1, both wrap to 0.
  - The first edge after reset release gives counter_H=1, counter_V=0.
- Decodes:
  - hsync, vsync, display_on, line_start and frame_start are registered.
  - Each is computed from the next-state counter values, so it is coherent with counter_H/counter_V in the same cycle (zero relative latency).
- hsync timing:
  - hsync = SYNC_POL when H_ACTIVE+H_FRONT <= counter_H < H_ACTIVE+H_FRONT+H_SYNC, i.e. 656..751.
  - Otherwise ~SYNC_POL.
- vsync timing:
  - vsync = SYNC_POL for the entire lines V_ACTIVE+V_FRONT <= counter_V < V_ACTIVE+V_FRONT+V_SYNC, i.e. 490..491.
  - This includes blanking pixels of those lines.
- Strobes:
  - line_start is high exactly one cycle per line.
  - frame_start is high exactly one cycle per frame, coincident with a line_start.
  - Neither asserts during reset or on the first post-reset cycle (the count is 1,0).
  - The first frame_start occurs at the first wrap to (0,0).
- Delay line:
  - hsync_d/vsync_d/display_on_d equal the undelayed signals exactly PIPE_DELAY cycles earlier.
  - PIPE_DELAY=0 makes them wires to the undelayed registers.
  - The delay line shifts every cycle; there is no stall.
- Reset mid-frame:
  - Takes effect on the next edge: counters go to 0 and the delay line flushes to inactive.
  - No partial sync pulse survives reset.
- Out-of-range parameters (any zero porch/sync width, totals > 1023) are illegal; no behaviour is defined for them.

Test Plan:
- Reset held 4 cycles, then released -> during reset counters 0, hsync=vsync=1, display_on=0, pixel_out=0; first cycle after release counter_H=1, counter_V=0, display_on=1.
- Run one line -> display_on falls when counter_H reaches 640; hsync=0 exactly for counter_H 656..751 (96 cycles); counter_H 799->0 with counter_V 0->1 and line_start=1.
- Run to line 489 -> vsync=0 from (0,490) through (799,491), i.e. 1600 cycles; display_on=0 for all lines 480..524.
- Run full frame -> at counter (799,524) the next edge gives (0,0) with frame_start=1 and line_start=1; 420000 cycles between frame_start pulses.
- Default PIPE_DELAY=3, colour_in=1 constantly -> display_on_d, hsync_d, vsync_d match the undelayed signals shifted 3 cycles; pixel_out=1 only while display_on_d=1. Repeat with PIPE_DELAY=0 for zero shift.
- Assert reset for 1 cycle at counter (700,100) while hsync=0 -> next cycle counters (0,0), hsync=hsync_d=1, display_on_d=0; the count resumes cleanly with no extra sync edge.
